// File: rtl/data_ram_ctrl.sv
// Word-organised data RAM with byte/half/word stores, fault classification,
// a sticky first-fault record and load/store completion counters.
module data_ram_ctrl #(
  parameter int          WORD_AW   = 12,
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [2:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  input  logic        fault_clr_i,
  output logic        fault_o,
  output logic [1:0]  fault_type_o,
  output logic [31:0] fault_addr_o,
  output logic [31:0] rd_cnt_o,
  output logic [31:0] wr_cnt_o
);

  localparam int          DEPTH = 1 << WORD_AW;
  localparam logic [32:0] SPAN  = 33'd4 << WORD_AW;

  localparam logic [2:0] SEL_BYTE = 3'b000;
  localparam logic [2:0] SEL_HALF = 3'b001;
  localparam logic [2:0] SEL_WORD = 3'b010;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_ALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE = 2'b10;
  localparam logic [1:0] CAUSE_SEL   = 2'b11;

  typedef enum logic {
    FAULT_IDLE,
    FAULT_LATCHED
  } fault_state_t;

  logic [31:0]        mem [DEPTH];

  logic [31:0]        offset;
  logic               in_range;
  logic               sel_ok;
  logic               misaligned;
  logic [1:0]         cause;
  logic               access_ok;
  logic               fault_now;
  logic               rd_ok;
  logic               wr_ok;
  logic [WORD_AW-1:0] idx;
  logic [31:0]        wdata;
  logic [3:0]         be;

  fault_state_t       fault_state;
  logic [1:0]         fault_type_q;
  logic [31:0]        fault_addr_q;
  logic [31:0]        rd_cnt_q;
  logic [31:0]        wr_cnt_q;

  // Address decode and fault classification; illegal size wins over range,
  // range wins over alignment.
  always_comb begin
    offset     = mem_addr_i - BASE_ADDR;
    in_range   = {1'b0, offset} < SPAN;
    idx        = offset[WORD_AW+1:2];
    sel_ok     = (mem_sel_i == SEL_BYTE) || (mem_sel_i == SEL_HALF) ||
                 (mem_sel_i == SEL_WORD);
    misaligned = ((mem_sel_i == SEL_HALF) && mem_addr_i[0]) ||
                 ((mem_sel_i == SEL_WORD) && (mem_addr_i[1:0] != 2'b00));
    cause = CAUSE_NONE;
    if (!sel_ok) begin
      cause = CAUSE_SEL;
    end else if (!in_range) begin
      cause = CAUSE_RANGE;
    end else if (misaligned) begin
      cause = CAUSE_ALIGN;
    end
    access_ok = mem_ce_i && (cause == CAUSE_NONE);
    fault_now = mem_ce_i && (cause != CAUSE_NONE);
    rd_ok     = access_ok && !mem_we_i;
    wr_ok     = access_ok && mem_we_i && !rst;
  end

  // The whole word is returned on loads and on stores (pre-store value);
  // lane selection is left to the requester.
  always_comb begin
    mem_data_o = 32'h0;
    if (access_ok) begin
      mem_data_o = mem[idx];
    end
  end

  // Store data replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wdata = mem_data_i;
    be    = 4'b0000;
    case (mem_sel_i)
      SEL_BYTE: begin
        wdata = {4{mem_data_i[7:0]}};
        be    = 4'b0001 << mem_addr_i[1:0];
      end
      SEL_HALF: begin
        wdata = {2{mem_data_i[15:0]}};
        be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      SEL_WORD: begin
        wdata = mem_data_i;
        be    = 4'b1111;
      end
      default: begin
        wdata = mem_data_i;
        be    = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (be[lane]) begin
          mem[idx][8*lane +: 8] <= wdata[8*lane +: 8];
        end
      end
    end
  end

  // Sticky fault record: the first fault wins until cleared, but a clear that
  // coincides with a new fault re-arms the record with that new fault.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_state  <= FAULT_IDLE;
      fault_type_q <= CAUSE_NONE;
      fault_addr_q <= 32'h0;
    end else begin
      case (fault_state)
        FAULT_IDLE: begin
          if (fault_now) begin
            fault_state  <= FAULT_LATCHED;
            fault_type_q <= cause;
            fault_addr_q <= mem_addr_i;
          end
        end
        FAULT_LATCHED: begin
          if (fault_clr_i && fault_now) begin
            fault_type_q <= cause;
            fault_addr_q <= mem_addr_i;
          end else if (fault_clr_i) begin
            fault_state  <= FAULT_IDLE;
            fault_type_q <= CAUSE_NONE;
            fault_addr_q <= 32'h0;
          end
        end
        default: begin
          fault_state  <= FAULT_IDLE;
          fault_type_q <= CAUSE_NONE;
          fault_addr_q <= 32'h0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= 32'h0;
      wr_cnt_q <= 32'h0;
    end else begin
      if (rd_ok) begin
        rd_cnt_q <= rd_cnt_q + 32'd1;
      end
      if (access_ok && mem_we_i) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
    end
  end

  assign fault_o      = (fault_state == FAULT_LATCHED);
  assign fault_type_o = fault_type_q;
  assign fault_addr_o = fault_addr_q;
  assign rd_cnt_o     = rd_cnt_q;
  assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Bench for data_ram_ctrl: directed vector table, hand-written reset/wrap
// sequences and a random load/store phase against a shadow word model.
module tb_data_ram_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk;
  logic        rst;
  logic        mem_ce_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [2:0]  mem_sel_i;
  logic [31:0] mem_data_i;
  logic [31:0] mem_data_o;
  logic        fault_clr_i;
  logic        fault_o;
  logic [1:0]  fault_type_o;
  logic [31:0] fault_addr_o;
  logic [31:0] rd_cnt_o;
  logic [31:0] wr_cnt_o;

  data_ram_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ce_i     (mem_ce_i),
    .mem_we_i     (mem_we_i),
    .mem_addr_i   (mem_addr_i),
    .mem_sel_i    (mem_sel_i),
    .mem_data_i   (mem_data_i),
    .mem_data_o   (mem_data_o),
    .fault_clr_i  (fault_clr_i),
    .fault_o      (fault_o),
    .fault_type_o (fault_type_o),
    .fault_addr_o (fault_addr_o),
    .rd_cnt_o     (rd_cnt_o),
    .wr_cnt_o     (wr_cnt_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ce;
    logic        we;
    logic [2:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic        clr;
    logic        chk;
    logic [31:0] exp_rd;
    logic        exp_f;
    logic [1:0]  exp_t;
    logic [31:0] exp_fa;
    logic [31:0] exp_rc;
    logic [31:0] exp_wc;
  } vec_t;

  logic [31:0] exp_q[$];
  vec_t        vecs[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] shadow[8];
  logic [31:0] rc_m;
  logic [31:0] wc_m;

  function automatic vec_t mk(input logic ce, input logic we, input logic [2:0] sel,
                              input logic [31:0] off, input logic [31:0] data,
                              input logic clr, input logic chk, input logic [31:0] exp_rd,
                              input logic f, input logic [1:0] t, input logic [31:0] fa_off,
                              input logic [31:0] rc, input logic [31:0] wc);
    vec_t v;
    v.ce     = ce;
    v.we     = we;
    v.sel    = sel;
    v.addr   = BASE + off;
    v.data   = data;
    v.clr    = clr;
    v.chk    = chk;
    v.exp_rd = exp_rd;
    v.exp_f  = f;
    v.exp_t  = t;
    v.exp_fa = f ? BASE + fa_off : 32'h0;
    v.exp_rc = rc;
    v.exp_wc = wc;
    return v;
  endfunction

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_ce_i    = 1'b0;
    mem_we_i    = 1'b0;
    mem_addr_i  = 32'h0;
    mem_sel_i   = 3'b000;
    mem_data_i  = 32'h0;
    fault_clr_i = 1'b0;
  endtask

  // driver: one access per cycle, read data sampled mid-cycle, registered
  // state sampled just after the capturing edge
  task automatic apply(input vec_t v, input string tag);
    logic [31:0] exp_rd;
    @(negedge clk);
    mem_ce_i    = v.ce;
    mem_we_i    = v.we;
    mem_sel_i   = v.sel;
    mem_addr_i  = v.addr;
    mem_data_i  = v.data;
    fault_clr_i = v.clr;
    if (v.chk) exp_q.push_back(v.exp_rd);
    #2;
    if (v.chk) begin
      exp_rd = exp_q.pop_front();
      check({tag, " rdata"}, mem_data_o, exp_rd);
    end
    @(posedge clk);
    #1;
    check({tag, " fault"}, {31'h0, fault_o}, {31'h0, v.exp_f});
    check({tag, " ftype"}, {30'h0, fault_type_o}, {30'h0, v.exp_t});
    check({tag, " faddr"}, fault_addr_o, v.exp_fa);
    check({tag, " rdcnt"}, rd_cnt_o, v.exp_rc);
    check({tag, " wrcnt"}, wr_cnt_o, v.exp_wc);
    idle_inputs();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, " fault"}, {31'h0, fault_o}, 32'h0);
    check({tag, " ftype"}, {30'h0, fault_type_o}, 32'h0);
    check({tag, " faddr"}, fault_addr_o, 32'h0);
    check({tag, " rdcnt"}, rd_cnt_o, 32'h0);
    check({tag, " wrcnt"}, wr_cnt_o, 32'h0);
  endtask

  initial begin
    int          i;
    int          op;
    int          lane;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [31:0] off;
    logic [31:0] pre;

    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_cleared("reset");
    check("reset rdata", mem_data_o, 32'h0);

    //            ce we sel     off           data          clr chk exp_rd        f  t      fa_off        rc wc
    vecs.push_back(mk(1, 1, 3'd2, 32'h10,       32'hDEADBEEF, 0, 0, 32'h0,        0, 2'b00, 32'h0,        0, 1));
    vecs.push_back(mk(1, 0, 3'd2, 32'h10,       32'h0,        0, 1, 32'hDEADBEEF, 0, 2'b00, 32'h0,        1, 1));
    vecs.push_back(mk(1, 1, 3'd2, 32'h10,       32'h0,        0, 1, 32'hDEADBEEF, 0, 2'b00, 32'h0,        1, 2));
    vecs.push_back(mk(1, 1, 3'd0, 32'h13,       32'hFFFFFF5A, 0, 1, 32'h0,        0, 2'b00, 32'h0,        1, 3));
    vecs.push_back(mk(1, 0, 3'd2, 32'h10,       32'h0,        0, 1, 32'h5A000000, 0, 2'b00, 32'h0,        2, 3));
    vecs.push_back(mk(1, 1, 3'd1, 32'h12,       32'hEEEE1234, 0, 1, 32'h5A000000, 0, 2'b00, 32'h0,        2, 4));
    vecs.push_back(mk(1, 1, 3'd1, 32'h10,       32'hFFFFABCD, 0, 1, 32'h12340000, 0, 2'b00, 32'h0,        2, 5));
    vecs.push_back(mk(1, 0, 3'd2, 32'h10,       32'h0,        0, 1, 32'h1234ABCD, 0, 2'b00, 32'h0,        3, 5));
    vecs.push_back(mk(1, 1, 3'd0, 32'h11,       32'h00000077, 0, 1, 32'h1234ABCD, 0, 2'b00, 32'h0,        3, 6));
    vecs.push_back(mk(1, 0, 3'd1, 32'h12,       32'h0,        0, 1, 32'h123477CD, 0, 2'b00, 32'h0,        4, 6));
    vecs.push_back(mk(0, 1, 3'd7, 32'h10,       32'h0,        0, 1, 32'h0,        0, 2'b00, 32'h0,        4, 6));
    vecs.push_back(mk(1, 0, 3'd0, 32'h10,       32'h0,        0, 1, 32'h123477CD, 0, 2'b00, 32'h0,        5, 6));
    vecs.push_back(mk(1, 1, 3'd2, 32'h20,       32'h11111111, 0, 0, 32'h0,        0, 2'b00, 32'h0,        5, 7));
    vecs.push_back(mk(1, 1, 3'd2, 32'h22,       32'hCAFEF00D, 0, 1, 32'h0,        1, 2'b01, 32'h22,       5, 7));
    vecs.push_back(mk(1, 0, 3'd2, 32'h20,       32'h0,        0, 1, 32'h11111111, 1, 2'b01, 32'h22,       6, 7));
    vecs.push_back(mk(1, 0, 3'd7, 32'h10,       32'h0,        0, 1, 32'h0,        1, 2'b01, 32'h22,       6, 7));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h0,        1, 1, 32'h0,        0, 2'b00, 32'h0,        6, 7));
    vecs.push_back(mk(1, 0, 3'd2, 32'h4000,     32'h0,        1, 1, 32'h0,        1, 2'b10, 32'h4000,     6, 7));
    vecs.push_back(mk(1, 0, 3'd1, 32'h11,       32'h0,        1, 1, 32'h0,        1, 2'b01, 32'h11,       6, 7));
    vecs.push_back(mk(1, 1, 3'd1, 32'h21,       32'h5555,     0, 1, 32'h0,        1, 2'b01, 32'h11,       6, 7));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 2'b00, 32'h0,        6, 7));
    vecs.push_back(mk(1, 0, 3'd2, 32'hFFFFFFFC, 32'h0,        0, 1, 32'h0,        1, 2'b10, 32'hFFFFFFFC, 6, 7));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 2'b00, 32'h0,        6, 7));
    vecs.push_back(mk(1, 1, 3'd2, 32'h3FFC,     32'h0BADF00D, 0, 0, 32'h0,        0, 2'b00, 32'h0,        6, 8));
    vecs.push_back(mk(1, 0, 3'd0, 32'h3FFF,     32'h0,        0, 1, 32'h0BADF00D, 0, 2'b00, 32'h0,        7, 8));
    vecs.push_back(mk(1, 0, 3'd3, 32'h4001,     32'h0,        0, 1, 32'h0,        1, 2'b11, 32'h4001,     7, 8));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 2'b00, 32'h0,        7, 8));
    vecs.push_back(mk(1, 0, 3'd2, 32'h4002,     32'h0,        0, 1, 32'h0,        1, 2'b10, 32'h4002,     7, 8));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 2'b00, 32'h0,        7, 8));
    vecs.push_back(mk(1, 1, 3'd4, 32'h10,       32'hFFFFFFFF, 0, 1, 32'h0,        1, 2'b11, 32'h10,       7, 8));
    vecs.push_back(mk(0, 0, 3'd0, 32'h0,        32'h0,        1, 0, 32'h0,        0, 2'b00, 32'h0,        7, 8));
    vecs.push_back(mk(1, 0, 3'd2, 32'h10,       32'h0,        0, 1, 32'h123477CD, 0, 2'b00, 32'h0,        8, 8));

    foreach (vecs[k]) apply(vecs[k], $sformatf("vec%0d", k));

    // load counter wrap
    @(negedge clk);
    force dut.rd_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.rd_cnt_q;
    apply(mk(1, 0, 3'd2, 32'h10, 32'h0, 0, 1, 32'h123477CD, 0, 2'b00, 32'h0, 32'hFFFF_FFFF, 8), "wrap1");
    apply(mk(1, 0, 3'd2, 32'h10, 32'h0, 0, 1, 32'h123477CD, 0, 2'b00, 32'h0, 32'h0, 8), "wrap2");
    apply(mk(1, 0, 3'd2, 32'h10, 32'h0, 0, 1, 32'h123477CD, 0, 2'b00, 32'h0, 32'h1, 8), "wrap3");
    apply(mk(1, 0, 3'd7, 32'h10, 32'h0, 0, 1, 32'h0, 1, 2'b11, 32'h10, 32'h1, 8), "prerst");

    // asynchronous reset mid-cycle, with a store held across a reset edge
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_cleared("async_rst");
    mem_ce_i   = 1'b1;
    mem_we_i   = 1'b1;
    mem_sel_i  = 3'd2;
    mem_addr_i = BASE + 32'h10;
    mem_data_i = 32'h99999999;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    apply(mk(1, 1, 3'd2, 32'h10, 32'hA5A5C3C3, 0, 1, 32'h123477CD, 0, 2'b00, 32'h0, 0, 1), "post_rst_st");
    apply(mk(1, 0, 3'd2, 32'h10, 32'h0, 0, 1, 32'hA5A5C3C3, 0, 2'b00, 32'h0, 1, 1), "post_rst_ld");

    // random loads/stores against a shadow of eight words
    rc_m = 32'd1;
    wc_m = 32'd1;
    for (int w = 0; w < 8; w++) begin
      data      = $urandom;
      shadow[w] = data;
      wc_m      = wc_m + 32'd1;
      apply(mk(1, 1, 3'd2, 32'h100 + 32'(4 * w), data, 0, 0, 32'h0, 0, 2'b00, 32'h0, rc_m, wc_m),
            $sformatf("init%0d", w));
    end
    for (int n = 0; n < 60; n++) begin
      i    = $urandom_range(0, 7);
      op   = $urandom_range(0, 1);
      sel  = 3'($urandom_range(0, 2));
      lane = $urandom_range(0, 3);
      data = $urandom;
      off  = 32'h100 + 32'(4 * i);
      if (sel == 3'd0) off = off + 32'(lane);
      if (sel == 3'd1) off = off + 32'(lane & 2);
      pre  = shadow[i];
      if (op == 0) begin
        rc_m = rc_m + 32'd1;
      end else begin
        wc_m = wc_m + 32'd1;
        case (sel)
          3'd0: shadow[i][8*lane +: 8] = data[7:0];
          3'd1: if (lane >= 2) shadow[i][31:16] = data[15:0];
                else shadow[i][15:0] = data[15:0];
          default: shadow[i] = data;
        endcase
      end
      apply(mk(1, op[0], sel, off, data, 0, 1, pre, 0, 2'b00, 32'h0, rc_m, wc_m),
            $sformatf("rand%0d", n));
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
